// File: rtl/id_pipe_pkg.sv
// ============================================================
// id_pipe_pkg : shared opcodes, type codes and FSM encodings
// Rev 1.0 - initial release
// ============================================================
`default_nettype none

package id_pipe_pkg;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_SYSTEM = 7'b1110011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;

    typedef enum logic [3:0] {
        R_TYPE      = 4'd0,
        I_TYPE      = 4'd1,
        J_TYPE      = 4'd2,
        JR_TYPE     = 4'd3,
        U_TYPE      = 4'd4,
        UPC_TYPE    = 4'd5,
        SYS_TYPE    = 4'd6,
        LOAD_TYPE   = 4'd7,
        STORE_TYPE  = 4'd8,
        BRANCH_TYPE = 4'd9,
        NO_TYPE     = 4'd15
    } inst_type_e;

    localparam logic [7:0] ALUCEX_NONE = 8'h00;
    localparam logic [7:0] ADD_TYPE    = 8'h01;
    localparam logic [7:0] JAL_TYPE    = 8'h02;
    localparam logic [7:0] JALR_TYPE   = 8'h03;
    localparam logic [7:0] LUI_TYPE    = 8'h04;
    localparam logic [7:0] AUIPC_TYPE  = 8'h05;

    typedef enum logic [0:0] {
        ST_RUN  = 1'b0,
        ST_HALT = 1'b1
    } state_e;

endpackage

`default_nettype wire

// File: rtl/id_decode.sv
// ============================================================
// id_decode : combinational instruction decoder
// Rev 1.0 - initial release
// ============================================================
`default_nettype none

module id_decode
    import id_pipe_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [31:0]     inst,
    input  logic [XLEN-1:0] pc,
    output inst_type_e      inst_type,
    output logic [4:0]      rs1_addr,
    output logic [4:0]      rs2_addr,
    output logic            rs1_ren,
    output logic            rs2_ren,
    output logic [4:0]      rd_addr,
    output logic            rd_wen,
    output logic [XLEN-1:0] imm,
    output logic [XLEN-1:0] op1_const,
    output logic [XLEN-1:0] op2_const,
    output logic [3:0]      aluc,
    output logic [7:0]      alucex,
    output logic            illegal
);

    logic [6:0]  w_opcode;
    logic [2:0]  w_f3;
    logic [6:0]  w_f7;
    logic [31:0] w_imm_i32, w_imm_s32, w_imm_b32, w_imm_u32, w_imm_j32;
    logic [XLEN-1:0] w_imm_i, w_imm_s, w_imm_b, w_imm_u, w_imm_j;

    assign w_opcode = inst[6:0];
    assign w_f3     = inst[14:12];
    assign w_f7     = inst[31:25];
    assign rs1_addr = inst[19:15];
    assign rs2_addr = inst[24:20];
    assign rd_addr  = rd_wen ? inst[11:7] : 5'd0;

    assign w_imm_i32 = {{20{inst[31]}}, inst[31:20]};
    assign w_imm_s32 = {{20{inst[31]}}, inst[31:25], inst[11:7]};
    assign w_imm_b32 = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
    assign w_imm_u32 = {inst[31:12], 12'b0};
    assign w_imm_j32 = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};

    // signed size-casts widen to RV64 by replicating bit 31
    assign w_imm_i = XLEN'($signed(w_imm_i32));
    assign w_imm_s = XLEN'($signed(w_imm_s32));
    assign w_imm_b = XLEN'($signed(w_imm_b32));
    assign w_imm_u = XLEN'($signed(w_imm_u32));
    assign w_imm_j = XLEN'($signed(w_imm_j32));

    always_comb begin
        inst_type = NO_TYPE;
        rs1_ren   = 1'b0;
        rs2_ren   = 1'b0;
        rd_wen    = 1'b0;
        imm       = '0;
        op1_const = '0;
        op2_const = '0;
        aluc      = 4'd0;
        alucex    = ALUCEX_NONE;
        illegal   = 1'b0;
        case (w_opcode)
            OPC_OP: begin
                inst_type = R_TYPE;
                rs1_ren   = 1'b1;
                rs2_ren   = 1'b1;
                rd_wen    = 1'b1;
                aluc      = {inst[30], w_f3};
                if (w_f3 == 3'b000 && w_f7 == 7'b0000000) alucex = ADD_TYPE;
            end
            OPC_OP_IMM: begin
                inst_type = I_TYPE;
                rs1_ren   = 1'b1;
                rd_wen    = 1'b1;
                imm       = w_imm_i;
                op2_const = w_imm_i;
                // only the shift-right pair uses bit 30 as an opcode bit
                aluc      = {(w_f3 == 3'b101) & inst[30], w_f3};
                if (w_f3 == 3'b000) alucex = ADD_TYPE;
            end
            OPC_JALR: begin
                inst_type = JR_TYPE;
                rs1_ren   = 1'b1;
                rd_wen    = 1'b1;
                imm       = w_imm_i;
                op2_const = w_imm_i;
                alucex    = JALR_TYPE;
            end
            OPC_LOAD: begin
                inst_type = LOAD_TYPE;
                rs1_ren   = 1'b1;
                rd_wen    = 1'b1;
                imm       = w_imm_i;
                op2_const = w_imm_i;
            end
            OPC_STORE: begin
                inst_type = STORE_TYPE;
                rs1_ren   = 1'b1;
                rs2_ren   = 1'b1;
                imm       = w_imm_s;
            end
            OPC_BRANCH: begin
                inst_type = BRANCH_TYPE;
                rs1_ren   = 1'b1;
                rs2_ren   = 1'b1;
                imm       = w_imm_b;
                aluc      = {1'b0, w_f3};
            end
            OPC_JAL: begin
                inst_type = J_TYPE;
                rd_wen    = 1'b1;
                imm       = w_imm_j;
                op1_const = w_imm_j;
                op2_const = pc;
                alucex    = JAL_TYPE;
            end
            OPC_LUI: begin
                inst_type = U_TYPE;
                rd_wen    = 1'b1;
                imm       = w_imm_u;
                op1_const = w_imm_u;
                alucex    = LUI_TYPE;
            end
            OPC_AUIPC: begin
                inst_type = UPC_TYPE;
                rd_wen    = 1'b1;
                imm       = w_imm_u;
                op1_const = w_imm_u;
                op2_const = pc;
                alucex    = AUIPC_TYPE;
            end
            OPC_SYSTEM: begin
                inst_type = SYS_TYPE;
                imm       = w_imm_i;
            end
            default: illegal = 1'b1;
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/id_pipe.sv
// ============================================================
// id_pipe : decode stage register with forwarding, halt FSM, retire count
// Rev 1.0 - initial release
// ============================================================
`default_nettype none

module id_pipe
    import id_pipe_pkg::*;
#(
    parameter int XLEN   = 32,
    parameter bit FWD_EN = 1'b1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     in_inst,
    input  logic [XLEN-1:0] in_pc,
    input  logic            flush,
    output logic [4:0]      rs1_addr,
    output logic [4:0]      rs2_addr,
    output logic            rs1_ren,
    output logic            rs2_ren,
    input  logic [XLEN-1:0] rs1_data,
    input  logic [XLEN-1:0] rs2_data,
    input  logic            fwd_wen,
    input  logic [4:0]      fwd_addr,
    input  logic [XLEN-1:0] fwd_data,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_pc,
    output logic [XLEN-1:0] out_op1,
    output logic [XLEN-1:0] out_op2,
    output logic [XLEN-1:0] out_imm,
    output logic [4:0]      out_rd_addr,
    output logic            out_rd_wen,
    output logic [3:0]      out_aluc,
    output logic [7:0]      out_alucex,
    output logic            out_illegal,
    output logic            halted,
    output logic            halt_good,
    output logic [31:0]     retire_cnt
);

    inst_type_e      w_inst_type;
    logic [4:0]      w_rd_addr;
    logic            w_rd_wen;
    logic [XLEN-1:0] w_imm, w_op1_const, w_op2_const;
    logic [XLEN-1:0] w_rs1_val, w_rs2_val, w_op1, w_op2;
    logic [3:0]      w_aluc;
    logic [7:0]      w_alucex;
    logic            w_illegal;
    logic            w_accept, w_drain;
    state_e          r_state;

    id_decode #(.XLEN(XLEN)) u_decode (
        .inst      (in_inst),
        .pc        (in_pc),
        .inst_type (w_inst_type),
        .rs1_addr  (rs1_addr),
        .rs2_addr  (rs2_addr),
        .rs1_ren   (rs1_ren),
        .rs2_ren   (rs2_ren),
        .rd_addr   (w_rd_addr),
        .rd_wen    (w_rd_wen),
        .imm       (w_imm),
        .op1_const (w_op1_const),
        .op2_const (w_op2_const),
        .aluc      (w_aluc),
        .alucex    (w_alucex),
        .illegal   (w_illegal)
    );

    // x0 is hard zero even if EX claims to be writing it
    always_comb begin
        w_rs1_val = rs1_data;
        w_rs2_val = rs2_data;
        if (FWD_EN && fwd_wen && fwd_addr == rs1_addr) w_rs1_val = fwd_data;
        if (FWD_EN && fwd_wen && fwd_addr == rs2_addr) w_rs2_val = fwd_data;
        if (rs1_addr == 5'd0) w_rs1_val = '0;
        if (rs2_addr == 5'd0) w_rs2_val = '0;
    end

    assign w_op1    = rs1_ren ? w_rs1_val : w_op1_const;
    assign w_op2    = rs2_ren ? w_rs2_val : w_op2_const;
    assign in_ready = !halted && (!out_valid || out_ready);
    assign w_accept = in_valid && in_ready;
    assign w_drain  = out_valid && out_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid   <= 1'b0;
            out_pc      <= '0;
            out_op1     <= '0;
            out_op2     <= '0;
            out_imm     <= '0;
            out_rd_addr <= 5'd0;
            out_rd_wen  <= 1'b0;
            out_aluc    <= 4'd0;
            out_alucex  <= 8'd0;
            out_illegal <= 1'b0;
        end else if (flush) begin
            out_valid <= 1'b0;
        end else if (w_accept) begin
            out_valid   <= 1'b1;
            out_pc      <= in_pc;
            out_op1     <= w_op1;
            out_op2     <= w_op2;
            out_imm     <= w_imm;
            out_rd_addr <= w_rd_addr;
            out_rd_wen  <= w_rd_wen;
            out_aluc    <= w_aluc;
            out_alucex  <= w_alucex;
            out_illegal <= w_illegal;
        end else if (w_drain) begin
            out_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= ST_RUN;
            halted    <= 1'b0;
            halt_good <= 1'b0;
        end else begin
            case (r_state)
                ST_RUN: begin
                    if (w_accept && !flush && w_inst_type == SYS_TYPE) begin
                        r_state   <= ST_HALT;
                        halted    <= 1'b1;
                        halt_good <= (in_inst[14:12] == 3'b000);
                    end
                end
                ST_HALT: halted <= 1'b1;
                default: r_state <= ST_RUN;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)       retire_cnt <= 32'd0;
        else if (w_drain) retire_cnt <= retire_cnt + 32'd1;
    end

endmodule

`default_nettype wire

// File: tb/tb_id_pipe.sv
// ============================================================
// tb_id_pipe : directed and randomized checks of id_pipe
// Rev 1.0 - initial release
// ============================================================
`default_nettype none

module tb_id_pipe;
    import id_pipe_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0, in_ready, flush = 1'b0;
    logic [31:0] in_inst = 32'd0, in_pc = 32'd0;
    logic [4:0]  rs1_addr, rs2_addr;
    logic        rs1_ren, rs2_ren;
    logic [31:0] rs1_data = 32'd0, rs2_data = 32'd0;
    logic        fwd_wen = 1'b0;
    logic [4:0]  fwd_addr = 5'd0;
    logic [31:0] fwd_data = 32'd0;
    logic        out_valid, out_ready = 1'b1;
    logic [31:0] out_pc, out_op1, out_op2, out_imm;
    logic [4:0]  out_rd_addr;
    logic        out_rd_wen, out_illegal, halted, halt_good;
    logic [3:0]  out_aluc;
    logic [7:0]  out_alucex;
    logic [31:0] retire_cnt;

    int n_pass = 0;
    int n_total = 0;

    id_pipe #(.XLEN(32), .FWD_EN(1'b1)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_inst(in_inst), .in_pc(in_pc), .flush(flush),
        .rs1_addr(rs1_addr), .rs2_addr(rs2_addr), .rs1_ren(rs1_ren), .rs2_ren(rs2_ren),
        .rs1_data(rs1_data), .rs2_data(rs2_data),
        .fwd_wen(fwd_wen), .fwd_addr(fwd_addr), .fwd_data(fwd_data),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_pc(out_pc), .out_op1(out_op1), .out_op2(out_op2), .out_imm(out_imm),
        .out_rd_addr(out_rd_addr), .out_rd_wen(out_rd_wen), .out_aluc(out_aluc),
        .out_alucex(out_alucex), .out_illegal(out_illegal),
        .halted(halted), .halt_good(halt_good), .retire_cnt(retire_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] pc, op1, op2, imm;
        logic [4:0]  rd;
        logic        rd_wen;
        logic [3:0]  aluc;
        logic [7:0]  alucex;
        logic        illegal;
        logic        r1en, r2en;
    } exp_t;

    exp_t        m_out;
    logic        m_valid, m_halted, m_good;
    logic [31:0] m_retire;

    // Reference decode built from the field-layout rules using shifts and masks
    function automatic exp_t ref_decode(input logic [31:0] inst, pc, r1, r2,
                                        input logic fw, input logic [4:0] fa, input logic [31:0] fd);
        exp_t e;
        logic [31:0] s1, s2, ii, is, ib, iu, ij, sx;
        logic [4:0]  a1, a2;
        logic [2:0]  f3;
        a1 = inst[19:15];
        a2 = inst[24:20];
        f3 = inst[14:12];
        s1 = (a1 == 0) ? 32'd0 : ((fw && fa == a1) ? fd : r1);
        s2 = (a2 == 0) ? 32'd0 : ((fw && fa == a2) ? fd : r2);
        sx = inst;
        ii = $unsigned($signed(sx) >>> 20);
        is = (ii & 32'hFFFF_FFE0) | 32'(inst[11:7]);
        ib = ($unsigned($signed(sx) >>> 19) & 32'hFFFF_F000) | (32'(inst[7]) << 11)
             | (32'(inst[30:25]) << 5) | (32'(inst[11:8]) << 1);
        iu = inst & 32'hFFFF_F000;
        ij = ($unsigned($signed(sx) >>> 11) & 32'hFFF0_0000) | (inst & 32'h000F_F000)
             | (32'(inst[20]) << 11) | (32'(inst[30:21]) << 1);
        e = '{pc: pc, op1: 0, op2: 0, imm: 0, rd: 0, rd_wen: 0, aluc: 0, alucex: 0,
              illegal: 0, r1en: 0, r2en: 0};
        case (inst[6:0])
            7'b0110011: begin
                e.op1 = s1; e.op2 = s2; e.rd_wen = 1; e.r1en = 1; e.r2en = 1;
                e.aluc = {inst[30], f3};
                e.alucex = (f3 == 0 && inst[31:25] == 0) ? ADD_TYPE : 8'h00;
            end
            7'b0010011: begin
                e.op1 = s1; e.op2 = ii; e.imm = ii; e.rd_wen = 1; e.r1en = 1;
                e.aluc = {(f3 == 3'd5) ? inst[30] : 1'b0, f3};
                e.alucex = (f3 == 0) ? ADD_TYPE : 8'h00;
            end
            7'b1100111: begin e.op1 = s1; e.op2 = ii; e.imm = ii; e.rd_wen = 1; e.r1en = 1; e.alucex = JALR_TYPE; end
            7'b0000011: begin e.op1 = s1; e.op2 = ii; e.imm = ii; e.rd_wen = 1; e.r1en = 1; end
            7'b0100011: begin e.op1 = s1; e.op2 = s2; e.imm = is; e.r1en = 1; e.r2en = 1; end
            7'b1100011: begin e.op1 = s1; e.op2 = s2; e.imm = ib; e.r1en = 1; e.r2en = 1; e.aluc = {1'b0, f3}; end
            7'b1101111: begin e.op1 = ij; e.op2 = pc; e.imm = ij; e.rd_wen = 1; e.alucex = JAL_TYPE; end
            7'b0110111: begin e.op1 = iu; e.imm = iu; e.rd_wen = 1; e.alucex = LUI_TYPE; end
            7'b0010111: begin e.op1 = iu; e.op2 = pc; e.imm = iu; e.rd_wen = 1; e.alucex = AUIPC_TYPE; end
            7'b1110011: e.imm = ii;
            default:    e.illegal = 1;
        endcase
        e.rd = e.rd_wen ? inst[11:7] : 5'd0;
        return e;
    endfunction

    function automatic logic [146:0] pack_exp(input exp_t e);
        return {e.pc, e.op1, e.op2, e.imm, e.rd, e.rd_wen, e.aluc, e.alucex, e.illegal};
    endfunction

    function automatic logic [31:0] rand_inst();
        logic [31:0] r;
        logic [6:0]  o;
        r = $urandom;
        case ($urandom_range(0, 10))
            0: o = 7'b0110011;  1: o = 7'b0010011;  2: o = 7'b1101111;
            3: o = 7'b1100111;  4: o = 7'b0110111;  5: o = 7'b0010111;
            6: o = 7'b0000011;  7: o = 7'b0100011;  8: o = 7'b1100011;
            9: o = 7'h7F;       default: o = 7'h2B;
        endcase
        if (o == 7'b0110011 && $urandom_range(0, 2) != 0)
            r[31:25] = $urandom_range(0, 1) ? 7'h00 : 7'h20;
        if ($urandom_range(0, 3) == 0) r[14:12] = 3'b000;
        return {r[31:7], o};
    endfunction

    // Advance one clock, updating the transaction-level model alongside the DUT
    task automatic tick();
        logic rdy, acc, fo;
        exp_t d;
        rdy = !m_halted && (!m_valid || out_ready);
        acc = in_valid && rdy;
        fo  = m_valid && out_ready;
        d   = ref_decode(in_inst, in_pc, rs1_data, rs2_data, fwd_wen, fwd_addr, fwd_data);
        @(posedge clk);
        if (fo) m_retire = m_retire + 1;
        if (flush) m_valid = 0;
        else if (acc) begin
            m_valid = 1;
            m_out = d;
            if (in_inst[6:0] == 7'b1110011) begin
                m_halted = 1;
                m_good = (in_inst[14:12] == 3'b000);
            end
        end else if (fo) m_valid = 0;
        #1;
    endtask

    task automatic idle();
        in_valid = 0; flush = 0; fwd_wen = 0; fwd_addr = 0; fwd_data = 0;
        rs1_data = 0; rs2_data = 0; in_inst = 32'h0000_0013; in_pc = 32'h0000_1000;
    endtask

    task automatic do_reset();
        idle();
        out_ready = 1;
        rst_n = 0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1;
        m_valid = 0; m_halted = 0; m_good = 0; m_retire = 0;
        m_out = ref_decode(32'h7F, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic test_reset();
        do_reset();
        n_total++; if ({out_valid, halted, halt_good} !== 3'b000) $display("FAIL reset_flags got=%b exp=000", {out_valid, halted, halt_good}); else n_pass++;
        n_total++; if ({out_pc, out_op1, out_op2, out_imm, out_rd_addr, out_rd_wen, out_aluc, out_alucex, out_illegal} !== 147'd0)
            $display("FAIL reset_fields got=%h exp=0", {out_pc, out_op1, out_op2, out_imm, out_rd_addr, out_rd_wen, out_aluc, out_alucex, out_illegal}); else n_pass++;
        n_total++; if (retire_cnt !== 32'd0) $display("FAIL reset_retire got=%h exp=0", retire_cnt); else n_pass++;
        n_total++; if (in_ready !== 1'b1) $display("FAIL reset_in_ready got=%b exp=1", in_ready); else n_pass++;
    endtask

    task automatic test_addi();
        do_reset();
        in_valid = 1; in_inst = 32'hFFF1_0093; rs1_data = 32'd5; #1;
        n_total++; if ({rs1_addr, rs1_ren, rs2_ren} !== {5'd2, 1'b1, 1'b0}) $display("FAIL addi_rf got=%h exp=%h", {rs1_addr, rs1_ren, rs2_ren}, {5'd2, 2'b10}); else n_pass++;
        tick();
        in_valid = 0;
        n_total++; if ({out_valid, out_op1, out_op2} !== {1'b1, 32'd5, 32'hFFFF_FFFF}) $display("FAIL addi_ops got=%h exp=%h", {out_valid, out_op1, out_op2}, {1'b1, 32'd5, 32'hFFFF_FFFF}); else n_pass++;
        n_total++; if ({out_rd_addr, out_rd_wen, out_alucex} !== {5'd1, 1'b1, ADD_TYPE}) $display("FAIL addi_ctl got=%h exp=%h", {out_rd_addr, out_rd_wen, out_alucex}, {5'd1, 1'b1, ADD_TYPE}); else n_pass++;
    endtask

    task automatic test_forward();
        do_reset();
        in_valid = 1; in_inst = 32'h0010_81B3; rs1_data = 0; rs2_data = 0;
        fwd_wen = 1; fwd_addr = 5'd1; fwd_data = 32'h1234; #1;
        tick();
        n_total++; if ({out_op1, out_op2} !== {32'h1234, 32'h1234}) $display("FAIL fwd_hit got=%h exp=%h", {out_op1, out_op2}, {32'h1234, 32'h1234}); else n_pass++;
        in_inst = 32'h0000_01B3; fwd_addr = 5'd0; rs1_data = 32'hDEAD; rs2_data = 32'hBEEF; #1;
        tick();
        n_total++; if ({out_valid, out_op1, out_op2} !== {1'b1, 64'd0}) $display("FAIL fwd_x0 got=%h exp=%h", {out_valid, out_op1, out_op2}, {1'b1, 64'd0}); else n_pass++;
        idle();
    endtask

    task automatic test_back_to_back();
        do_reset();
        out_ready = 0; in_valid = 1; in_inst = 32'hFFF1_0093; rs1_data = 32'h11; #1;
        tick();
        rs1_data = 32'h22;
        for (int i = 0; i < 3; i++) begin
            n_total++; if (in_ready !== 1'b0) $display("FAIL stall_in_ready cyc=%0d got=%b exp=0", i, in_ready); else n_pass++;
            tick();
            n_total++; if ({out_valid, out_op1, retire_cnt} !== {1'b1, 32'h11, 32'd0}) $display("FAIL stall_hold cyc=%0d got=%h exp=%h", i, {out_valid, out_op1, retire_cnt}, {1'b1, 32'h11, 32'd0}); else n_pass++;
        end
        out_ready = 1; #1;
        n_total++; if (in_ready !== 1'b1) $display("FAIL release_in_ready got=%b exp=1", in_ready); else n_pass++;
        tick();
        rs1_data = 32'h33;
        n_total++; if ({out_valid, out_op1, retire_cnt} !== {1'b1, 32'h22, 32'd1}) $display("FAIL b2b_first got=%h exp=%h", {out_valid, out_op1, retire_cnt}, {1'b1, 32'h22, 32'd1}); else n_pass++;
        tick();
        in_valid = 0;
        n_total++; if ({out_valid, out_op1, retire_cnt} !== {1'b1, 32'h33, 32'd2}) $display("FAIL b2b_second got=%h exp=%h", {out_valid, out_op1, retire_cnt}, {1'b1, 32'h33, 32'd2}); else n_pass++;
        tick();
        n_total++; if ({out_valid, retire_cnt} !== {1'b0, 32'd3}) $display("FAIL b2b_drain got=%h exp=%h", {out_valid, retire_cnt}, {1'b0, 32'd3}); else n_pass++;
    endtask

    task automatic test_flush();
        do_reset();
        in_valid = 1; flush = 1; in_inst = 32'h0020_8463; rs1_data = 32'hA; rs2_data = 32'hB; #1;
        tick();
        n_total++; if ({out_valid, retire_cnt} !== {1'b0, 32'd0}) $display("FAIL flush_kill got=%h exp=%h", {out_valid, retire_cnt}, {1'b0, 32'd0}); else n_pass++;
        flush = 0;
        tick();
        in_valid = 0;
        n_total++; if ({out_valid, out_op1, out_op2, out_imm, out_rd_wen} !== {1'b1, 32'hA, 32'hB, 32'd8, 1'b0})
            $display("FAIL beq_fields got=%h exp=%h", {out_valid, out_op1, out_op2, out_imm, out_rd_wen}, {1'b1, 32'hA, 32'hB, 32'd8, 1'b0}); else n_pass++;
    endtask

    task automatic test_illegal_async_reset();
        do_reset();
        in_valid = 1; in_inst = 32'h0000_007F; out_ready = 0; #1;
        tick();
        in_valid = 0;
        n_total++; if ({out_valid, out_illegal, out_rd_wen} !== 3'b110) $display("FAIL illegal got=%b exp=110", {out_valid, out_illegal, out_rd_wen}); else n_pass++;
        in_valid = 1; in_inst = 32'hFFF1_0093; rs1_data = 32'h77;
        tick();
        #2;
        rst_n = 0;
        #1;
        n_total++; if ({out_valid, out_pc, out_op1, out_op2, out_imm, out_rd_addr, out_rd_wen, out_aluc, out_alucex, out_illegal, retire_cnt, halted} !== 181'd0)
            $display("FAIL async_reset got=%h exp=0", {out_valid, out_pc, out_op1, out_op2, out_imm, out_rd_addr, out_rd_wen, out_aluc, out_alucex, out_illegal, retire_cnt, halted}); else n_pass++;
        do_reset();
    endtask

    task automatic test_halt();
        do_reset();
        in_valid = 1; flush = 1; in_inst = 32'h0010_0073; #1;
        tick();
        n_total++; if ({halted, out_valid} !== 2'b00) $display("FAIL halt_flush_prio got=%b exp=00", {halted, out_valid}); else n_pass++;
        flush = 0;
        tick();
        in_inst = 32'hFFF1_0093; #1;
        n_total++; if ({halted, halt_good, out_valid, out_illegal, in_ready} !== 5'b11100) $display("FAIL ebreak got=%b exp=11100", {halted, halt_good, out_valid, out_illegal, in_ready}); else n_pass++;
        tick();
        n_total++; if ({halted, out_valid, in_ready, retire_cnt} !== {3'b100, 32'd1}) $display("FAIL halt_stay got=%h exp=%h", {halted, out_valid, in_ready, retire_cnt}, {3'b100, 32'd1}); else n_pass++;
        do_reset();
        in_valid = 1; in_inst = 32'h0010_1073; #1;
        tick();
        in_valid = 0;
        n_total++; if ({halted, halt_good, out_valid} !== 3'b101) $display("FAIL csrrw got=%b exp=101", {halted, halt_good, out_valid}); else n_pass++;
    endtask

    task automatic test_random();
        exp_t cur;
        do_reset();
        for (int i = 0; i < 400; i++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 3) != 0);
            flush     = ($urandom_range(0, 9) == 0);
            in_inst   = rand_inst();
            in_pc     = $urandom & 32'hFFFF_FFFC;
            rs1_data  = $urandom;
            rs2_data  = $urandom;
            fwd_wen   = $urandom_range(0, 1);
            fwd_data  = $urandom;
            case ($urandom_range(0, 3))
                0: fwd_addr = in_inst[19:15];
                1: fwd_addr = in_inst[24:20];
                2: fwd_addr = 5'd0;
                default: fwd_addr = 5'($urandom);
            endcase
            #1;
            cur = ref_decode(in_inst, in_pc, rs1_data, rs2_data, fwd_wen, fwd_addr, fwd_data);
            n_total++; if ({in_ready, rs1_addr, rs2_addr, rs1_ren, rs2_ren} !== {!m_halted && (!m_valid || out_ready), in_inst[19:15], in_inst[24:20], cur.r1en, cur.r2en})
                $display("FAIL rnd_comb i=%0d got=%h exp=%h", i, {in_ready, rs1_addr, rs2_addr, rs1_ren, rs2_ren}, {!m_halted && (!m_valid || out_ready), in_inst[19:15], in_inst[24:20], cur.r1en, cur.r2en}); else n_pass++;
            tick();
            n_total++; if ({out_valid, halted, retire_cnt} !== {m_valid, m_halted, m_retire}) $display("FAIL rnd_state i=%0d got=%h exp=%h", i, {out_valid, halted, retire_cnt}, {m_valid, m_halted, m_retire}); else n_pass++;
            if (m_valid) begin
                n_total++; if ({out_pc, out_op1, out_op2, out_imm, out_rd_addr, out_rd_wen, out_aluc, out_alucex, out_illegal} !== pack_exp(m_out))
                    $display("FAIL rnd_fields i=%0d inst=%h got=%h exp=%h", i, m_out.pc, {out_pc, out_op1, out_op2, out_imm, out_rd_addr, out_rd_wen, out_aluc, out_alucex, out_illegal}, pack_exp(m_out)); else n_pass++;
            end
        end
        idle();
    endtask

    initial begin
        test_reset();
        test_addi();
        test_forward();
        test_back_to_back();
        test_flush();
        test_illegal_async_reset();
        test_halt();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/id_pipe.md
ID_PIPE -- requirements
Module: id_pipe

Interface
REQ-001 Parameter XLEN, default 32, datapath width; legal values 32 and 64; all immediates sign-extend to XLEN.
REQ-002 Parameter FWD_EN, default 1, enables the one-entry forwarding path from EX writeback.
REQ-003 clk  in  1  single clock; all state on rising edge.
REQ-004 rst_n  in  1  reset, asynchronous assert, active-low.
REQ-005 in_valid/in_ready  in/out  1/1  fetch-side handshake; in_inst in 32, in_pc in XLEN.
REQ-006 flush  in  1  kill the held instruction and the one offered this cycle.
REQ-007 rs1_addr, rs2_addr  out  5  register-file read addresses (combinational from in_inst[19:15], [24:20]); rs1_ren, rs2_ren out 1.
REQ-008 rs1_data, rs2_data  in  XLEN  register-file read data, same cycle as address.
REQ-009 fwd_wen in 1, fwd_addr in 5, fwd_data in XLEN  EX result forwarding source.
REQ-010 out_valid/out_ready  out/in  1/1  EX-side handshake.
REQ-011 out_pc, out_op1, out_op2, out_imm  out  XLEN; out_rd_addr out 5; out_rd_wen out 1; out_aluc out 4; out_alucex out 8; out_illegal out 1.
REQ-012 halted out 1, halt_good out 1, retire_cnt out 32.

Function
REQ-013 Decode SHALL cover opcodes OP, OP-IMM, JAL, JALR, LUI, AUIPC, SYSTEM plus new LOAD(0000011), STORE(0100011), BRANCH(1100011); any other opcode SHALL yield NO_TYPE with out_illegal=1, out_rd_wen=0.
REQ-014 Immediates: I=inst[31:20]; S={inst[31:25],inst[11:7]}; B={inst[31],inst[7],inst[30:25],inst[11:8],0}; U={inst[31:12],12'b0}; J={inst[31],inst[19:12],inst[20],inst[30:21],0}; all sign-extended to XLEN.
REQ-015 Operands: R/BRANCH op1=rs1,op2=rs2; OP-IMM/JALR/LOAD op1=rs1,op2=immI; STORE op1=rs1,op2=rs2,out_imm=immS; JAL op1=immJ,op2=pc; LUI op1=immU,op2=0; AUIPC op1=immU,op2=pc; BRANCH out_imm=immB.
REQ-016 rs1_ren=1 for R/I/JALR/LOAD/STORE/BRANCH; rs2_ren=1 for R/STORE/BRANCH; rd_wen=1 for R/I/JAL/JALR/LUI/AUIPC/LOAD, 0 otherwise.
REQ-017 out_alucex: ADD_TYPE when func3=000 and (I-type, or R-type with func7=0000000); JAL/JALR/LUI/AUIPC give their dedicated codes; else 0.
REQ-018 Register x0 reads SHALL return 0 regardless of rs*_data or forwarding.
REQ-019 When FWD_EN=1, fwd_wen=1, fwd_addr!=0 and fwd_addr equals the source address, operand SHALL take fwd_data instead of rs*_data.
REQ-020 Output is a single register stage: latency 1 cycle from input handshake to out_valid.
REQ-021 in_ready = !halted && (!out_valid || out_ready); combinational, no dependency on in_valid.
REQ-022 Accept on in_valid&&in_ready; output register loads decoded fields; out_valid=1 next cycle.
REQ-023 out_* SHALL hold stable while out_valid=1 and out_ready=0.
REQ-024 flush=1: next cycle out_valid=0; any input accepted that cycle is discarded; flush has priority over load and over halt entry.
REQ-025 FSM RUN->HALT when a SYSTEM instruction is accepted (not flushed); halt_good=1 if func3=000 else 0; HALT exits only via reset; SYSTEM instruction itself still presented at output.
REQ-026 retire_cnt increments on out_valid&&out_ready, wraps 0xFFFFFFFF->0.
REQ-027 Simultaneous drain and accept (out_valid&&out_ready&&in_valid) SHALL load new entry with no bubble.

Reset
REQ-028 rst_n=0: out_valid=0, all out_* data fields 0, FSM=RUN, halted=0, halt_good=0, retire_cnt=0; mid-transfer data dropped.
REQ-029 Deassertion takes effect on the following rising edge; in_ready=1 first cycle after reset.

Structure
REQ-030 Opcode values, inst-type codes (R_TYPE…NO_TYPE, new LOAD/STORE/BRANCH_TYPE), alucex codes and FSM state encodings SHALL live in the shared define package.
REQ-031 Combinational decode SHALL be sub-module id_decode; id_pipe holds handshake, forwarding, FSM and counter.

Verification
REQ-032 addi x1,x2,-1 (0xFFF10093), rs1_data=5 -> op1=5, op2=0xFFFFFFFF, rd=1, rd_wen=1, alucex=ADD_TYPE, one cycle later.
REQ-033 add x3,x1,x1 with fwd_wen=1,fwd_addr=1,fwd_data=0x1234, rs1_data=0 -> op1=op2=0x1234; same with fwd_addr=0 -> op1=0.
REQ-034 out_ready=0 three cycles with in_valid=1 -> in_ready=0, out_* stable, retire_cnt unchanged; release -> back-to-back transfers, no bubble.
REQ-035 flush same cycle as accepting beq -> next cycle out_valid=0, retire_cnt unchanged.
REQ-036 ebreak 0x00100073 -> halted=1, halt_good=1, in_ready=0 thereafter; csrrw (func3=001) -> halt_good=0.
REQ-037 Opcode 0x7F -> out_illegal=1, rd_wen=0; rst_n low mid-stall -> all outputs 0 asynchronously.
